// File: rtl/aq_f_spsram_param.sv
// Parametrised single-port SRAM wrapper with an ASIC-style interface
// (A/CEN/GWEN/WEN/D/Q). The array is split into DATA_WIDTH/WRAP_SIZE slices,
// each with one write enable. After reset the array is optionally swept to
// zero, and INIT_DONE reports when user accesses are accepted.
// Read data is registered and write-first, and it holds while the RAM is deselected.
// DATA_WIDTH must be an integer multiple of WRAP_SIZE.
module aq_f_spsram_param #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 88,
    parameter int WRAP_SIZE  = 44,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_DONE
);

    localparam int NSLICE = DATA_WIDTH / WRAP_SIZE;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    // One extra bit so the counter can reach DEPTH, the "sweep finished" value.
    localparam int CNT_W  = ADDR_WIDTH + 1;

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_init_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_holding;
    logic                  r_init_done;

    logic                  w_sweep_end;
    logic                  w_sweep_we;
    logic                  w_access;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_unused_wen;

    // Without INIT_ZERO, the sweep has nothing to do and ends on the first edge.
    assign w_sweep_end = (INIT_ZERO == 0) || (r_init_cnt == CNT_W'(DEPTH));
    assign w_sweep_we  = (r_state == S_INIT) && (INIT_ZERO != 0) && !w_sweep_end;
    assign w_access    = (r_state == S_READY) && !CEN;
    assign w_addr      = CEN ? r_addr_holding : A;
    assign w_mem_addr  = (r_state == S_INIT) ? r_init_cnt[ADDR_WIDTH-1:0] : w_addr;

    // Only the top bit of each slice's WEN field is used.
    assign w_unused_wen = ^WEN;

    assign INIT_DONE = r_init_done;

    // Init sweep FSM: walk every address once, then open for user access
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == S_INIT) begin
            if (w_sweep_end) begin
                r_state     <= S_READY;
                r_init_done <= 1'b1;
            end else if (w_sweep_we) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    // Remember the last selected address for use while deselected
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_addr_holding <= '0;
        end else if (!CEN) begin
            r_addr_holding <= A;
        end
    end

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        logic [WRAP_SIZE-1:0] r_mem [DEPTH];
        logic [WRAP_SIZE-1:0] r_q;
        logic [WRAP_SIZE-1:0] w_d;
        logic                 w_slice_we;

        assign w_d        = D[gi*WRAP_SIZE +: WRAP_SIZE];
        assign w_slice_we = w_access && !GWEN && !WEN[(gi+1)*WRAP_SIZE-1];

        // Slice storage: zero-fill during the sweep, user writes once ready
        always_ff @(posedge CLK) begin
            if (w_sweep_we) begin
                r_mem[w_mem_addr] <= '0;
            end else if (w_slice_we) begin
                r_mem[w_mem_addr] <= w_d;
            end
        end

        // Registered read data: write-first, forced to 0 during init, held when deselected
        always_ff @(posedge CLK or negedge RST_B) begin
            if (!RST_B) begin
                r_q <= '0;
            end else if (r_state == S_INIT) begin
                r_q <= '0;
            end else if (!CEN) begin
                r_q <= w_slice_we ? w_d : r_mem[w_mem_addr];
            end
        end

        assign Q[gi*WRAP_SIZE +: WRAP_SIZE] = r_q;
    end

endmodule

// File: tb/tb_aq_f_spsram_param.sv
// Self-checking bench for aq_f_spsram_param. It instantiates the default 64x88 configuration
// and a 16x64 configuration with four slices and no zero sweep, and checks both
// against behavioural array models.
module tb_aq_f_spsram_param;

    localparam int SWEEP = 65;  // edges from reset release to INIT_DONE, 64-deep array

    logic        clk;
    logic        rst_b;
    logic [5:0]  a;
    logic        cen, gwen;
    logic [87:0] wen, d;
    logic [87:0] q;
    logic        done;

    logic [3:0]  a2;
    logic        cen2, gwen2;
    logic [63:0] wen2, d2;
    logic [63:0] q2;
    logic        done2;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the 64x88 instance
    logic [87:0] m_mem [64];
    logic [87:0] m_q;
    logic        m_ready;
    int          m_edges;

    // Model of the 16x64 instance; k2 marks bits whose contents are known
    logic [63:0] m2_mem [16];
    logic [63:0] m2_k [16];
    logic [63:0] m2_q, m2_qk;
    logic        m2_ready;

    aq_f_spsram_param u_dut (
        .CLK       (clk),
        .RST_B     (rst_b),
        .A         (a),
        .CEN       (cen),
        .GWEN      (gwen),
        .WEN       (wen),
        .D         (d),
        .Q         (q),
        .INIT_DONE (done)
    );

    aq_f_spsram_param #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (64),
        .WRAP_SIZE  (16),
        .INIT_ZERO  (0)
    ) u_dut2 (
        .CLK       (clk),
        .RST_B     (rst_b),
        .A         (a2),
        .CEN       (cen2),
        .GWEN      (gwen2),
        .WEN       (wen2),
        .D         (d2),
        .Q         (q2),
        .INIT_DONE (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock edge: advance both models with the inputs in force, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst_b) begin
            if (!m_ready) begin
                m_edges++;
                m_q = '0;
                if (m_edges == SWEEP) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < 64; i++) m_mem[i] = '0;
                end
            end else if (!cen) begin
                for (int s = 0; s < 2; s++) begin
                    if (!gwen && !wen[s*44+43]) begin
                        m_mem[a][s*44 +: 44] = d[s*44 +: 44];
                    end
                    m_q[s*44 +: 44] = m_mem[a][s*44 +: 44];
                end
            end
            if (!m2_ready) begin
                m2_ready = 1'b1;
                m2_q     = '0;
                m2_qk    = '1;
            end else if (!cen2) begin
                for (int s = 0; s < 4; s++) begin
                    if (!gwen2 && !wen2[s*16+15]) begin
                        m2_mem[a2][s*16 +: 16] = d2[s*16 +: 16];
                        m2_k[a2][s*16 +: 16]   = '1;
                    end
                    m2_q[s*16 +: 16]  = m2_mem[a2][s*16 +: 16];
                    m2_qk[s*16 +: 16] = m2_k[a2][s*16 +: 16];
                end
            end
        end
        #1;
        check_eq("init_done", 128'(done), 128'(m_ready));
        check_eq("q", 128'(q), 128'(m_q));
        check_eq("init_done2", 128'(done2), 128'(m2_ready));
        check_eq("q2", 128'(q2 & m2_qk), 128'(m2_q & m2_qk));
    endtask

    task automatic assert_reset();
        rst_b    = 1'b0;
        m_ready  = 1'b0;
        m_edges  = 0;
        m_q      = '0;
        m2_ready = 1'b0;
        m2_q     = '0;
        m2_qk    = '1;
        #1;
        check_eq("rst_q", 128'(q), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic idle();
        cen  = 1'b1; gwen = 1'b1; wen  = '1; d = '0;
        cen2 = 1'b1; gwen2 = 1'b1; wen2 = '1; d2 = '0;
    endtask

    task automatic wr(input logic [5:0] ad, input logic [87:0] dat, input logic [87:0] we_n);
        a = ad; cen = 1'b0; gwen = 1'b0; wen = we_n; d = dat;
        tick();
    endtask

    task automatic rd(input logic [5:0] ad);
        a = ad; cen = 1'b0; gwen = 1'b1; wen = '1; d = 88'($urandom());
        tick();
    endtask

    initial begin
        logic [87:0] wmask;
        for (int i = 0; i < 16; i++) begin
            m2_mem[i] = '0;
            m2_k[i]   = '0;
        end
        a = '0; a2 = '0;
        idle();
        rst_b = 1'b1;
        #2;
        assert_reset();
        for (int i = 0; i < 3; i++) tick();

        // Writes during the sweep must be dropped
        release_reset();
        for (int i = 0; i < SWEEP; i++) begin
            if (i < 10) begin
                a = 6'd2; cen = 1'b0; gwen = 1'b0; wen = '0; d = '1;
            end else begin
                idle();
            end
            tick();
        end
        idle();
        check_eq("done_after_sweep", 128'(done), 128'(1));
        rd(6'd0);
        rd(6'd31);
        check_eq("rd31_zero", 128'(q), 128'(0));
        rd(6'd63);
        rd(6'd2);
        check_eq("rd2_dropped", 128'(q), 128'(0));

        // Lower slice only: write-first for lower, old zero for upper
        wmask = '1;
        wmask[43] = 1'b0;
        wr(6'd5, {11{8'hA5}}, wmask);
        check_eq("slice_wr", 128'(q), 128'({44'h0, 44'h5A5A5A5A5A5}));
        rd(6'd5);
        check_eq("slice_rd", 128'(q), 128'({44'h0, 44'h5A5A5A5A5A5}));

        // GWEN low with sampled WEN bits high acts as a read
        wmask = '0;
        wmask[43] = 1'b1;
        wmask[87] = 1'b1;
        wr(6'd5, '1, wmask);
        check_eq("gwen_nowen", 128'(q), 128'({44'h0, 44'h5A5A5A5A5A5}));

        // Hold while deselected, with writes attempted
        wr(6'd7, 88'h123, '0);
        rd(6'd7);
        for (int i = 0; i < 10; i++) begin
            a = 6'($urandom()); cen = 1'b1; gwen = 1'b0; wen = '0; d = '1;
            tick();
        end
        check_eq("hold_q", 128'(q), 128'(88'h123));
        for (int i = 0; i < 64; i += 9) rd(6'(i));

        // Back-to-back write then read
        wr(6'd40, 88'hDEAD_BEEF_0123_4567_89AB, '0);
        rd(6'd40);

        // Randomised traffic on a small address window
        for (int i = 0; i < 300; i++) begin
            a    = 6'($urandom_range(0, 7)) + 6'd56;
            cen  = ($urandom_range(0, 3) == 0);
            gwen = $urandom_range(0, 1) == 1;
            wen  = 88'({$urandom(), $urandom(), $urandom()});
            d    = 88'({$urandom(), $urandom(), $urandom()});
            tick();
        end
        idle();

        // Reset in the middle of a fresh sweep
        wr(6'd60, '1, '0);
        rd(6'd60);
        check_eq("fill60", 128'(q), 128'({88{1'b1}}));
        idle();
        assert_reset();
        tick();
        release_reset();
        for (int i = 0; i < 20; i++) tick();
        assert_reset();
        for (int i = 0; i < 3; i++) tick();
        release_reset();
        for (int i = 0; i < SWEEP; i++) tick();
        rd(6'd60);
        check_eq("rd60_cleared", 128'(q), 128'(0));
        idle();

        // 16x64, four slices: independent slice writes at both ends of the array
        for (int ad = 0; ad < 16; ad += 15) begin
            for (int s = 0; s < 4; s++) begin
                a2 = 4'(ad); cen2 = 1'b0; gwen2 = 1'b0;
                wen2 = '1;
                wen2[s*16+15] = 1'b0;
                d2 = {$urandom(), $urandom()};
                tick();
            end
        end
        for (int ad = 0; ad < 16; ad += 15) begin
            a2 = 4'(ad); cen2 = 1'b0; gwen2 = 1'b1; wen2 = '0; d2 = '1;
            tick();
            check_eq("p2_known", 128'(m2_qk), 128'({64{1'b1}}));
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aq_f_spsram_param.md
Name: aq_f_spsram_param

Overview:
- Parametrised FPGA single-port SRAM wrapper, the successor to the fixed-size 64x88 FPGA SRAM wrappers.
- Presents the ASIC-style SRAM interface (A/CEN/GWEN/WEN/D/Q) to core RAM users (caches, TLB, BHT).
- Built from DATA_WIDTH/WRAP_SIZE slices of fpga_ram, one per byte-lane-like segment.
- Adds over the fixed wrappers:
  - a post-reset zero-initialisation sweep with done flag;
  - write-first read data;
  - Q held stable while deselected.

Parameters:
- ADDR_WIDTH, 6, address bits; DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 88, total data width.
- WRAP_SIZE, 44, slice width. DATA_WIDTH must be an integer multiple; NSLICE = DATA_WIDTH/WRAP_SIZE.
- INIT_ZERO, 1:
  - 1 = zero all entries after reset.
  - 0 = skip the sweep (contents undefined).

Ports:
- CLK, input, 1: clock; all state on rising edge.
- RST_B, input, 1: asynchronous active-low reset.
- A, input, ADDR_WIDTH: address.
- CEN, input, 1: chip enable, active low.
- GWEN, input, 1: global write enable, active low.
- WEN, input, DATA_WIDTH: bit write enables, active low. Only bit (i+1)*WRAP_SIZE-1 is sampled for slice i; other bits are ignored.
- D, input, DATA_WIDTH: write data.
- Q, output, DATA_WIDTH: read data.
- INIT_DONE, output, 1: high once the array is usable; accesses before it are dropped.

Behaviour:
- FSM states:
  - S_INIT: entered on reset. Counter init_cnt walks 0..DEPTH-1, writing 0 to all slices at init_cnt, one address per cycle.
  - S_READY: normal operation.
  - Transition: when init_cnt==DEPTH-1 is written, move to S_READY next cycle.
  - INIT_ZERO=0: S_INIT lasts exactly one cycle after RST_B deassert, with no writes.
- Reset values: state=S_INIT, init_cnt=0, addr_holding=0, Q=0, INIT_DONE=0.
  - Reset assertion mid-sweep or mid-access aborts immediately. The sweep restarts from address 0 after deassert.
- INIT_DONE:
  - Registered; rises in the same cycle the FSM enters S_READY.
  - Sweep latency from RST_B deassert to INIT_DONE=1 is DEPTH+1 edges (INIT_ZERO=1) or 1 edge (INIT_ZERO=0).
- During S_INIT:
  - External CEN/GWEN/WEN/D/A are ignored; no user write lands.
  - Q is forced to 0.
- Access, in S_READY with CEN=0:
  - Read: GWEN=1. Q = mem[A] one cycle after the edge.
  - Write: GWEN=0. Slice i is written when WEN[(i+1)*WRAP_SIZE-1]=0.
  - Q after a write cycle:
    - written slices return D (write-first);
    - unwritten slices return the old mem[A] slice.
- Deselect (CEN=1):
  - addr_holding keeps the last selected address.
  - No write occurs regardless of GWEN/WEN.
  - Q holds its previous value unchanged for any number of cycles.
- Address: addr = CEN ? addr_holding : A. addr_holding is updated on every edge with CEN=0.
- Wrap: A is taken modulo DEPTH by width; no out-of-range handling.
- Back-to-back:
  - A write followed by a read of the same address on the next cycle returns the new data. No hazard stall.
- GWEN=0 with all sampled WEN bits high: no slice written; Q returns old mem[A] (behaves as a read).
- Timing: everything is single-cycle. No backpressure, no ready output beyond INIT_DONE.

Test Plan:
- Reset/init:
  - Drive RST_B low 3 cycles, then release (ADDR_WIDTH=6, INIT_ZERO=1) -> INIT_DONE rises exactly 65 edges later.
  - Then read addresses 0, 31, 63 -> Q=0 each, one cycle latency.
- Slice write:
  - Write A=5, D=88'hA5..A5 with WEN[43]=0, WEN[87]=1 -> Q next cycle = {44'h0, 44'h...A5} (write-first, upper slice old zero).
  - Then read A=5 -> same value.
- Hold:
  - Read A=7 holding 88'h123, then CEN=1 for 10 cycles with A toggling and GWEN=0 -> Q stays 88'h123; mem[A-values] unchanged on subsequent reads.
- Access during init:
  - Issue write A=2, D=all-ones while INIT_DONE=0 -> dropped. Read A=2 after INIT_DONE -> 0.
- Reset mid-sweep:
  - Fill A=60 with 1s after init; assert RST_B when init_cnt=20 of a new sweep; release -> INIT_DONE again after 65 edges, and A=60 reads 0.
- Parameter sweep:
  - ADDR_WIDTH=4, DATA_WIDTH=64, WRAP_SIZE=16, INIT_ZERO=0 -> INIT_DONE 1 edge after reset.
  - Independent writes to each of the 4 slices read back correctly at A=0 and A=15.
